// File: rtl/serial_adder_n.sv
// serial_adder_n: WIDTH-bit adder computed DIGIT bits per clock through a single
// DIGIT-bit slice with a registered carry. Define SERIAL_ADD_OVF_EN to add the ovf output.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; result registers hold the last result
  // RUN   | one digit per cycle through the slice
  // DONE  | one-cycle result pulse; start here chains the next operation
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder_n: WIDTH must be >= 2 and divisible by DIGIT");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  always_comb begin
    {dcarry, dsum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                   + (DIGIT+1)'(carry);
    // partial sums enter at the top so the finished word is LSB-aligned
    acc_next = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    last = (cnt == CW'(STEPS - 1));
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_next;
  // carry into the MSB recovered from the top bit of the final digit
  assign ovf_next = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1] ^ dcarry;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= dcarry;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= acc_next;
            Cout  <= dcarry;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= ovf_next;
`endif
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
